rob_commit_ctrl: RTL and testbench

In-order commit sequencer for the register file's rename/dependency scheme. It owns a circular buffer of reorder-buffer entries and allocates a rob id to each issued instruction. It records common-data-bus writebacks, answers the register file's two operand lookups in the same cycle, and retires the head entry to the register file one per cycle. On a branch mispredict it flushes all in-flight entries.

---
 rtl/rob_commit_ctrl_pkg.sv | 14 +
 rtl/rob_commit_ctrl_if.sv | 39 +++
 rtl/rob_commit_ctrl_lookup_port.sv | 27 ++
 rtl/rob_commit_ctrl.sv | 116 +++++++++++
 tb/tb_rob_commit_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared sizing and types for the reorder-buffer commit controller.
package rob_commit_ctrl_pkg;

  localparam int ROB_SIZE_WIDTH = 3;
  localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;
  localparam int RD_W           = 5;
  localparam int DATA_W         = 32;

  typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;
  typedef logic [ROB_SIZE_WIDTH:0]   rob_cnt_t;
  typedef logic [RD_W-1:0]           rd_t;
  typedef logic [DATA_W-1:0]         data_t;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Issue / writeback / lookup / commit bundle between the pipeline and the ROB.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic    rdy;
  logic    issue_valid;
  rd_t     issue_rd;
  logic    issue_ready;
  rob_id_t issue_rob_id;
  logic    wb_valid;
  rob_id_t wb_rob_id;
  data_t   wb_value;
  rob_id_t ask_rob_id1;
  rob_id_t ask_rob_id2;
  data_t   get_value1;
  data_t   get_value2;
  logic    get_ready1;
  logic    get_ready2;
  rd_t     commit_rd;
  data_t   commit_value;
  rob_id_t commit_rob_id;
  logic    flush;
  logic    empty;

  modport master (
    output rdy, issue_valid, issue_rd, wb_valid, wb_rob_id, wb_value,
           ask_rob_id1, ask_rob_id2, flush,
    input  issue_ready, issue_rob_id, get_value1, get_value2, get_ready1,
           get_ready2, commit_rd, commit_value, commit_rob_id, empty
  );

  modport slave (
    input  rdy, issue_valid, issue_rd, wb_valid, wb_rob_id, wb_value,
           ask_rob_id1, ask_rob_id2, flush,
    output issue_ready, issue_rob_id, get_value1, get_value2, get_ready1,
           get_ready2, commit_rd, commit_value, commit_rob_id, empty
  );

endinterface

// File: rtl/rob_commit_ctrl_lookup_port.sv
// One register-file operand lookup: stored result, or the CDB value arriving this cycle.
module rob_lookup_port
  import rob_commit_ctrl_pkg::*;
(
  input  rob_id_t                         ask_id,
  input  logic [ROB_SIZE-1:0]             busy,
  input  logic [ROB_SIZE-1:0]             ready,
  input  logic [ROB_SIZE-1:0][DATA_W-1:0] value,
  input  logic                            wb_valid,
  input  rob_id_t                         wb_rob_id,
  input  data_t                           wb_value,
  output logic                            get_ready,
  output data_t                           get_value
);

  logic wb_hit;

  always_comb begin
    wb_hit    = wb_valid && (wb_rob_id == ask_id);
    get_ready = busy[ask_id] && (ready[ask_id] || wb_hit);
    get_value = '0;
    if (get_ready) begin
      get_value = wb_hit ? wb_value : value[ask_id];
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer sequencer: allocates ids, records writebacks, retires the head.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  rob_commit_ctrl_if.slave bus
);

  rob_id_t                         head;
  rob_id_t                         tail;
  rob_cnt_t                        count;
  logic [ROB_SIZE-1:0]             busy;
  logic [ROB_SIZE-1:0]             ready;
  logic [ROB_SIZE-1:0][RD_W-1:0]   rd_q;
  logic [ROB_SIZE-1:0][DATA_W-1:0] value_q;

  logic issue_ready;
  logic issue_fire;
  logic commit_fire;
  logic wb_fire;

  // Full is judged on the registered count only, so a retiring head frees no slot this cycle.
  assign issue_ready = (count != rob_cnt_t'(ROB_SIZE));
  assign issue_fire  = bus.issue_valid && issue_ready && bus.rdy && !bus.flush;
  assign commit_fire = busy[head] && ready[head] && bus.rdy && !bus.flush;
  assign wb_fire     = bus.wb_valid && busy[bus.wb_rob_id] && bus.rdy && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (wb_fire) begin
          ready[bus.wb_rob_id] <= 1'b1;
        end
        // Later assignments win: retiring the head overrides a same-cycle writeback to it.
        if (commit_fire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + rob_id_t'(1);
        end
        if (issue_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + rob_id_t'(1);
        end
        unique case ({issue_fire, commit_fire})
          2'b10:   count <= count + rob_cnt_t'(1);
          2'b01:   count <= count - rob_cnt_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (wb_fire) begin
      value_q[bus.wb_rob_id] <= bus.wb_value;
    end
    if (issue_fire) begin
      rd_q[tail] <= bus.issue_rd;
    end
  end

  always_comb begin
    bus.commit_rd     = '0;
    bus.commit_value  = '0;
    bus.commit_rob_id = '0;
    if (commit_fire) begin
      bus.commit_rd     = rd_q[head];
      bus.commit_value  = value_q[head];
      bus.commit_rob_id = head;
    end
  end

  assign bus.issue_ready  = issue_ready;
  assign bus.issue_rob_id = tail;
  assign bus.empty        = (count == '0);

  rob_lookup_port u_lookup1 (
    .ask_id    (bus.ask_rob_id1),
    .busy      (busy),
    .ready     (ready),
    .value     (value_q),
    .wb_valid  (bus.wb_valid),
    .wb_rob_id (bus.wb_rob_id),
    .wb_value  (bus.wb_value),
    .get_ready (bus.get_ready1),
    .get_value (bus.get_value1)
  );

  rob_lookup_port u_lookup2 (
    .ask_id    (bus.ask_rob_id2),
    .busy      (busy),
    .ready     (ready),
    .value     (value_q),
    .wb_valid  (bus.wb_valid),
    .wb_rob_id (bus.wb_rob_id),
    .wb_value  (bus.wb_value),
    .get_ready (bus.get_ready2),
    .get_value (bus.get_value2)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed vector table for the documented corner cases, then random traffic against a queue model.
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic    chk;
    logic    rst;
    logic    rdy;
    logic    iv;
    rd_t     ird;
    logic    wv;
    rob_id_t wid;
    data_t   wval;
    rob_id_t a1;
    logic    fl;
    logic    e_ir;
    rob_id_t e_iid;
    logic    e_empty;
    rd_t     e_crd;
    data_t   e_cval;
    rob_id_t e_cid;
    logic    e_gr;
    data_t   e_gv;
  } vec_t;

  typedef struct {
    int    id;
    rd_t   rd;
    bit    done;
    data_t val;
  } ment_t;

  vec_t  tbl[$];
  ment_t mq[$];
  int    m_tail;

  function automatic vec_t mk(int chk, int r, int rdy, int iv, int ird, int wv, int wid,
                              int wval, int a1, int fl, int ir, int iid, int emp,
                              int crd, int cval, int cid, int gr, int gv);
    vec_t v;
    v.chk = chk[0];  v.rst = r[0];       v.rdy = rdy[0];  v.iv = iv[0];
    v.ird = ird[4:0]; v.wv = wv[0];      v.wid = wid[2:0]; v.wval = wval;
    v.a1 = a1[2:0];  v.fl = fl[0];       v.e_ir = ir[0];  v.e_iid = iid[2:0];
    v.e_empty = emp[0]; v.e_crd = crd[4:0]; v.e_cval = cval; v.e_cid = cid[2:0];
    v.e_gr = gr[0];  v.e_gv = gv;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy, input logic iv, input rd_t ird,
                                input logic wv, input rob_id_t wid, input data_t wval,
                                input rob_id_t a1, input rob_id_t a2, input logic fl);
    rst             = r;
    bus.rdy         = rdy;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.wb_valid    = wv;
    bus.wb_rob_id   = wid;
    bus.wb_value    = wval;
    bus.ask_rob_id1 = a1;
    bus.ask_rob_id2 = a2;
    bus.flush       = fl;
  endtask

  function automatic int m_find(int id);
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k].id == id) return k;
    end
    return -1;
  endfunction

  task automatic check_lookup(input string name, input rob_id_t a, input logic gr, input data_t gv);
    int    idx;
    bit    hit;
    bit    exp_r;
    data_t exp_v;
    idx   = m_find(int'(a));
    hit   = bus.wb_valid && (bus.wb_rob_id == a);
    exp_r = (idx >= 0) && (mq[idx].done || hit);
    exp_v = '0;
    if (exp_r) exp_v = hit ? bus.wb_value : mq[idx].val;
    check_output({name, "_ready"}, 32'(gr), 32'(exp_r));
    check_output({name, "_value"}, gv, exp_v);
  endtask

  // Expected outputs come from the in-order list of live instructions.
  task automatic check_model();
    bit    cm;
    cm = (mq.size() > 0) && mq[0].done && bus.rdy && !bus.flush;
    check_output("rnd_issue_ready", 32'(bus.issue_ready), 32'(mq.size() < ROB_SIZE));
    check_output("rnd_issue_rob_id", 32'(bus.issue_rob_id), 32'(m_tail));
    check_output("rnd_empty", 32'(bus.empty), 32'(mq.size() == 0));
    check_output("rnd_commit_rd", 32'(bus.commit_rd), cm ? 32'(mq[0].rd) : 32'd0);
    check_output("rnd_commit_value", bus.commit_value, cm ? mq[0].val : 32'd0);
    check_output("rnd_commit_rob_id", 32'(bus.commit_rob_id), cm ? 32'(mq[0].id) : 32'd0);
    check_lookup("rnd_get1", bus.ask_rob_id1, bus.get_ready1, bus.get_value1);
    check_lookup("rnd_get2", bus.ask_rob_id2, bus.get_ready2, bus.get_value2);
  endtask

  task automatic update_model();
    bit cm;
    bit is;
    int idx;
    if (rst) begin
      mq.delete();
      m_tail = 0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        mq.delete();
        m_tail = 0;
      end else begin
        cm = (mq.size() > 0) && mq[0].done;
        is = bus.issue_valid && (mq.size() < ROB_SIZE);
        idx = m_find(int'(bus.wb_rob_id));
        if (bus.wb_valid && idx >= 0) begin
          mq[idx].done = 1'b1;
          mq[idx].val  = bus.wb_value;
        end
        if (cm) void'(mq.pop_front());
        if (is) begin
          mq.push_back('{id: m_tail, rd: bus.issue_rd, done: 1'b0, val: 32'd0});
          m_tail = (m_tail + 1) % ROB_SIZE;
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    m_tail = 0;

    // Single issue, writeback, commit one cycle later, then empty.
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       0,0, 1,0,1, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 1,5, 0,0,0,       0,0, 1,0,1, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 0,0, 1,0,'h1234,  0,0, 1,1,0, 0,0,0,       1,'h1234));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       0,0, 1,1,0, 5,'h1234,0,  1,'h1234));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       0,0, 1,1,1, 0,0,0,       0,0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0,0,       0,0, 0,0,0, 0,0,0,       0,0));
    // Out-of-order writebacks still retire in order.
    tbl.push_back(mk(1,0,1, 1,3, 0,0,0,       1,0, 1,0,1, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 1,4, 0,0,0,       1,0, 1,1,0, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 0,0, 1,1,7,       1,0, 1,2,0, 0,0,0,       1,7));
    tbl.push_back(mk(1,0,1, 0,0, 1,0,9,       1,0, 1,2,0, 0,0,0,       1,7));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       1,0, 1,2,0, 3,9,0,       1,7));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       1,0, 1,2,0, 4,7,1,       1,7));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       1,0, 1,2,1, 0,0,0,       0,0));
    // Lookup bypass of a CDB value, then rdy low freezing the commit.
    tbl.push_back(mk(1,0,1, 1,9, 0,0,0,       2,0, 1,2,1, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 0,0, 1,2,'hAA,    2,0, 1,3,0, 0,0,0,       1,'hAA));
    tbl.push_back(mk(1,0,0, 1,11, 0,0,0,      2,0, 1,3,0, 0,0,0,       1,'hAA));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       2,0, 1,3,0, 9,'hAA,2,    1,'hAA));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       2,0, 1,3,1, 0,0,0,       0,0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0,0,       0,0, 0,0,0, 0,0,0,       0,0));
    // Fill to full, retire the head while full, slot reopens a cycle later.
    for (int i = 0; i < ROB_SIZE; i++)
      tbl.push_back(mk(1,0,1, 1,i+1, 0,0,0,   0,0, 1,i,(i==0), 0,0,0,  0,0));
    tbl.push_back(mk(1,0,1, 1,20, 1,0,'h55,   0,0, 0,0,0, 0,0,0,       1,'h55));
    tbl.push_back(mk(1,0,1, 1,20, 0,0,0,      0,0, 0,0,0, 1,'h55,0,    1,'h55));
    tbl.push_back(mk(1,0,1, 1,21, 0,0,0,      0,0, 1,0,0, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       0,0, 0,1,0, 0,0,0,       0,0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0,0,       0,0, 0,0,0, 0,0,0,       0,0));
    // Flush with a committable head; stale writebacks afterwards are dropped.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,1, 1,i+1, 0,0,0,   1,0, 1,i,(i==0), 0,0,0,  0,0));
    tbl.push_back(mk(1,0,1, 0,0, 1,1,11,      1,0, 1,3,0, 0,0,0,       1,11));
    tbl.push_back(mk(1,0,1, 0,0, 1,0,10,      1,0, 1,3,0, 0,0,0,       1,11));
    tbl.push_back(mk(1,0,1, 1,7, 1,2,12,      1,1, 1,3,0, 0,0,0,       1,11));
    tbl.push_back(mk(1,0,1, 0,0, 1,1,99,      1,0, 1,0,1, 0,0,0,       0,0));
    tbl.push_back(mk(1,0,1, 0,0, 0,0,0,       1,0, 1,0,1, 0,0,0,       0,0));

    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      v = tbl[i];
      apply_stimulus(v.rst, v.rdy, v.iv, v.ird, v.wv, v.wid, v.wval, v.a1, v.a1, v.fl);
      #4;
      if (v.chk) begin
        check_output($sformatf("row%0d_issue_ready", i), 32'(bus.issue_ready), 32'(v.e_ir));
        check_output($sformatf("row%0d_issue_rob_id", i), 32'(bus.issue_rob_id), 32'(v.e_iid));
        check_output($sformatf("row%0d_empty", i), 32'(bus.empty), 32'(v.e_empty));
        check_output($sformatf("row%0d_commit_rd", i), 32'(bus.commit_rd), 32'(v.e_crd));
        check_output($sformatf("row%0d_commit_value", i), bus.commit_value, v.e_cval);
        check_output($sformatf("row%0d_commit_rob_id", i), 32'(bus.commit_rob_id), 32'(v.e_cid));
        check_output($sformatf("row%0d_get_ready1", i), 32'(bus.get_ready1), 32'(v.e_gr));
        check_output($sformatf("row%0d_get_value1", i), bus.get_value1, v.e_gv);
        check_output($sformatf("row%0d_get_ready2", i), 32'(bus.get_ready2), 32'(v.e_gr));
        check_output($sformatf("row%0d_get_value2", i), bus.get_value2, v.e_gv);
      end
      @(posedge clk);
      #1;
    end

    // Random traffic from a fresh reset, checked every cycle against the queue model.
    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    mq.delete();
    m_tail = 0;
    for (int c = 0; c < 2000; c++) begin
      logic    r_rst;
      logic    r_rdy;
      logic    r_iv;
      logic    r_wv;
      logic    r_fl;
      rob_id_t r_wid;
      r_rst = ($urandom_range(0, 199) == 0);
      r_rdy = ($urandom_range(0, 9) != 0);
      r_iv  = ($urandom_range(0, 9) < 6);
      r_wv  = ($urandom_range(0, 1) == 1);
      r_fl  = ($urandom_range(0, 49) == 0);
      r_wid = rob_id_t'($urandom_range(0, ROB_SIZE - 1));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        r_wid = rob_id_t'(mq[$urandom_range(0, mq.size() - 1)].id);
      apply_stimulus(r_rst, r_rdy, r_iv, rd_t'($urandom_range(0, 31)), r_wv, r_wid, $urandom,
                     rob_id_t'($urandom_range(0, ROB_SIZE - 1)),
                     rob_id_t'($urandom_range(0, ROB_SIZE - 1)), r_fl);
      #4;
      check_model();
      @(posedge clk);
      update_model();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
